// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state type, defaults and strobe bit order for the matmul sequencer
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, PEND, CLEAR, READ, ACC, WRITE} state_t;
  localparam int N_DEF = 4;
  localparam int STB_CLR = 0;
  localparam int STB_RD = 1;
  localparam int STB_MAC = 2;
  localparam int STB_WE = 3;
  localparam int STB_W = 4;
  function automatic int addr_w(input int n);
    return $clog2(n * n);
  endfunction
endpackage

// File: rtl/matmul_idx_counter.sv
// matmul_idx_counter: nested k (inner), j, i (outer) index counter for the matrix walk
module matmul_idx_counter import matmul_pkg::*; #(
  parameter int N = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step_k,
  input  logic          step_ij,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          last_k,
  output logic          last_elem
);
  localparam logic [IW-1:0] MAX = IW'(N - 1);
  assign last_k = k == MAX;
  assign last_elem = i == MAX && j == MAX;
  // N is a power of two, so j and i wrap to zero on their own
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) {i, j, k} <= '0;
    else if (clear) {i, j, k} <= '0;
    else if (step_ij) begin
      k <= '0;
      j <= j + 1'b1;
      if (j == MAX) i <= i + 1'b1;
    end
    else if (step_k) k <= k + 1'b1;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: tick-paced FSM walking C = A*B over operand RAMs, MAC and result RAM
module matmul_sequencer import matmul_pkg::*; #(
  parameter int N = N_DEF,
  parameter int AW = addr_w(N)
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          tick_en,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          c_we,
  output logic [AW-1:0] c_addr
);
  localparam int IW = $clog2(N);
  state_t state, nxt;
  logic [IW-1:0] i, j, k;
  logic last_k, last_elem;
  logic [STB_W-1:0] stb;
  matmul_idx_counter #(.N(N), .IW(IW)) u_idx (
    .clk_in(clk_in),
    .reset_n(reset_n),
    .clear(abort || (state == IDLE && start)),
    .step_k(stb[STB_MAC] && !last_k),
    .step_ij(stb[STB_WE]),
    .i(i),
    .j(j),
    .k(k),
    .last_k(last_k),
    .last_elem(last_elem)
  );
  always_comb begin
    nxt = state;
    stb = '0;
    stb[STB_CLR] = tick_en && state == CLEAR;
    stb[STB_RD] = tick_en && state == READ;
    stb[STB_MAC] = tick_en && state == ACC;
    stb[STB_WE] = tick_en && state == WRITE;
    if (abort) nxt = IDLE;
    else if (state == IDLE) nxt = start ? (tick_en ? CLEAR : PEND) : IDLE;
    else if (tick_en)
      case (state)
        PEND:    nxt = CLEAR;
        CLEAR:   nxt = READ;
        READ:    nxt = ACC;
        ACC:     nxt = last_k ? WRITE : READ;
        WRITE:   nxt = last_elem ? IDLE : CLEAR;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt != IDLE;
      done <= !abort && stb[STB_WE] && last_elem;
    end
  assign mac_clr = stb[STB_CLR];
  assign rd_en = stb[STB_RD];
  assign mac_en = stb[STB_MAC];
  assign c_we = stb[STB_WE];
  // addresses come straight from the index registers, so they hold for the whole tick
  assign a_addr = AW'({i, k});
  assign b_addr = AW'({k, j});
  assign c_addr = AW'({i, j});
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: table-driven and random checks of the sequencer against a spec-level model
module tb_matmul_sequencer;
  typedef struct {int kind; int a; int b;} ev_t;
  typedef struct {int period; bit on_tick; bit rnd; bit hold; int exp_strobes; int exp_pend; int exp_span;} vec_t;
  logic clk_in = 0, reset_n = 0, tick_en = 0, start4 = 0, abort4 = 0, start2 = 0;
  logic busy4, done4, rd4, clr4, mac4, we4, busy2, done2, rd2, clr2, mac2, we2;
  logic [3:0] a4, b4, c4;
  logic [1:0] a2, b2, c2;
  int tests = 0, fails = 0, cyc = 0, period = 4, tcnt = 0;
  int strb4, pend4, done_n4, excl4, first4, last4, done_cyc4, last_we4, we_n4, done_busy4, ns4;
  int strb2, pend2, done_n2, excl2, done_cyc2, last_we2, ns2;
  int am[16], bm[16], cm[16];
  int ra, rb, acc;
  ev_t q4[$], q2[$];
  vec_t vt[5];

  always #5 clk_in = ~clk_in;

  matmul_sequencer #(.N(4)) u4 (
    .clk_in(clk_in), .reset_n(reset_n), .tick_en(tick_en), .start(start4), .abort(abort4),
    .busy(busy4), .done(done4), .rd_en(rd4), .a_addr(a4), .b_addr(b4),
    .mac_clr(clr4), .mac_en(mac4), .c_we(we4), .c_addr(c4));
  matmul_sequencer #(.N(2)) u2 (
    .clk_in(clk_in), .reset_n(reset_n), .tick_en(tick_en), .start(start2), .abort(1'b0),
    .busy(busy2), .done(done2), .rd_en(rd2), .a_addr(a2), .b_addr(b2),
    .mac_clr(clr2), .mac_en(mac2), .c_we(we2), .c_addr(c2));

  initial forever begin
    @(posedge clk_in);
    cyc = cyc + 1;
    #1;
    tcnt = (tcnt + 1 >= period) ? 0 : tcnt + 1;
    tick_en = tcnt == 0;
  end

  // behavioural RAMs and MAC plus an event log, sampled mid-cycle
  initial forever begin
    @(negedge clk_in);
    ns4 = int'(clr4) + int'(rd4) + int'(mac4) + int'(we4);
    if (ns4 > 1) excl4++;
    if (ns4 > 0) begin strb4++; if (first4 < 0) first4 = cyc; last4 = cyc; end
    if (tick_en && busy4 && ns4 == 0) pend4++;
    if (clr4) begin q4.push_back('{0, 0, 0}); acc = 0; end
    if (rd4) begin q4.push_back('{1, int'(a4), int'(b4)}); ra = am[a4]; rb = bm[b4]; end
    if (mac4) begin q4.push_back('{2, 0, 0}); acc += ra * rb; end
    if (we4) begin q4.push_back('{3, int'(c4), 0}); cm[c4] = acc; last_we4 = cyc; we_n4++; end
    if (done4) begin done_n4++; done_cyc4 = cyc; done_busy4 = int'(busy4); end
  end

  initial forever begin
    @(negedge clk_in);
    ns2 = int'(clr2) + int'(rd2) + int'(mac2) + int'(we2);
    if (ns2 > 1) excl2++;
    if (ns2 > 0) strb2++;
    if (tick_en && busy2 && ns2 == 0) pend2++;
    if (clr2) q2.push_back('{0, 0, 0});
    if (rd2) q2.push_back('{1, int'(a2), int'(b2)});
    if (mac2) q2.push_back('{2, 0, 0});
    if (we2) begin q2.push_back('{3, int'(c2), 0}); last_we2 = cyc; end
    if (done2) begin done_n2++; done_cyc2 = cyc; end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk_in);
    #2;
  endtask

  function automatic int outs4();
    return int'({busy4, done4, rd4, clr4, mac4, we4, a4, b4, c4});
  endfunction

  // expected strobe order derived directly from the nested i/j/k loops of C = A*B
  function automatic int first_bad(input int n, input ev_t q[$]);
    ev_t e[$];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        e.push_back('{0, 0, 0});
        for (int k = 0; k < n; k++) begin
          e.push_back('{1, i * n + k, k * n + j});
          e.push_back('{2, 0, 0});
        end
        e.push_back('{3, i * n + j, 0});
      end
    for (int x = 0; x < e.size(); x++)
      if (x >= q.size() || q[x].kind != e[x].kind || q[x].a != e[x].a || q[x].b != e[x].b) return x;
    return q.size() == e.size() ? -1 : e.size();
  endfunction

  function automatic int c_errors();
    int bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += am[i * 4 + k] * bm[k * 4 + j];
        if (cm[i * 4 + j] != s) bad++;
      end
    return bad;
  endfunction

  task automatic clr_mon();
    q4.delete(); q2.delete();
    strb4 = 0; pend4 = 0; done_n4 = 0; excl4 = 0; first4 = -1; last4 = 0; we_n4 = 0;
    done_cyc4 = 0; last_we4 = 0; done_busy4 = -1;
    strb2 = 0; pend2 = 0; done_n2 = 0; excl2 = 0; done_cyc2 = 0; last_we2 = 0;
    for (int x = 0; x < 16; x++) cm[x] = -1;
  endtask

  task automatic load(input bit rnd);
    for (int x = 0; x < 16; x++) begin
      am[x] = rnd ? int'($urandom_range(0, 255)) : int'(x / 4 == x % 4);
      bm[x] = rnd ? int'($urandom_range(0, 255)) : x + 1;
    end
  endtask

  task automatic kick4(input bit on_tick, input bit hold);
    for (int t = 0; t < 20 && tick_en != on_tick; t++) cyc1();
    start4 = 1;
    cyc1();
    if (!hold) start4 = 0;
  endtask

  task automatic wait_done4(input string nm, input int lim);
    int t = 0;
    while (done_n4 == 0 && t < lim) begin cyc1(); t++; end
    if (done_n4 == 0) chk({nm, "_timeout"}, t, -1);
  endtask

  task automatic wait_rd(input int n, input int lim);
    int t = 0;
    while (!(we_n4 == n && rd4) && t < lim) begin cyc1(); t++; end
    chk("wait_read", int'(we_n4 == n && rd4), 1);
  endtask

  initial begin
    int s;
    vt[0] = '{1, 1, 0, 0, 160, 0, 160};
    vt[1] = '{4, 0, 0, 0, 160, 1, 637};
    vt[2] = '{3, 1, 1, 0, 160, 0, 478};
    vt[3] = '{2, 0, 1, 0, 160, 1, 319};
    vt[4] = '{1, 1, 1, 1, 160, 0, 160};
    clr_mon();
    repeat (3) cyc1();
    chk("reset_outs4", outs4(), 0);
    chk("reset_outs2", int'({busy2, done2, rd2, clr2, mac2, we2, a2, b2, c2}), 0);
    reset_n = 1;
    repeat (4) cyc1();
    chk("idle_busy", int'(busy4), 0);

    foreach (vt[r]) begin
      period = vt[r].period;
      load(vt[r].rnd);
      repeat (4) cyc1();
      clr_mon();
      kick4(vt[r].on_tick, vt[r].hold);
      wait_done4($sformatf("row%0d", r), 3000);
      chk($sformatf("row%0d_strobes", r), strb4, vt[r].exp_strobes);
      chk($sformatf("row%0d_pend", r), pend4, vt[r].exp_pend);
      chk($sformatf("row%0d_span", r), last4 - first4 + 1, vt[r].exp_span);
      chk($sformatf("row%0d_done_n", r), done_n4, 1);
      chk($sformatf("row%0d_done_lat", r), done_cyc4 - last_we4, 1);
      chk($sformatf("row%0d_busy_at_done", r), done_busy4, 0);
      chk($sformatf("row%0d_excl", r), excl4, 0);
      chk($sformatf("row%0d_seq", r), first_bad(4, q4), -1);
      chk($sformatf("row%0d_c", r), c_errors(), 0);
      if (vt[r].hold) begin
        chk("hold_restart_clr", int'(clr4 && busy4), 1);
        start4 = 0;
        abort4 = 1;
        cyc1();
        abort4 = 0;
        chk("hold_abort_busy", int'(busy4), 0);
      end
    end

    period = 2;
    load(1);
    clr_mon();
    kick4(1, 0);
    for (int t = 0; t < 400 && we_n4 < 5; t++) cyc1();
    start4 = 1;
    cyc1();
    start4 = 0;
    wait_done4("busy_start", 1000);
    chk("busy_start_seq", first_bad(4, q4), -1);
    chk("busy_start_done", done_n4, 1);
    chk("busy_start_c", c_errors(), 0);

    period = 4;
    repeat (4) cyc1();
    clr_mon();
    kick4(1, 0);
    wait_rd(5, 1000);
    abort4 = 1;
    cyc1();
    abort4 = 0;
    chk("abort_busy", int'(busy4), 0);
    chk("abort_outs", outs4(), 0);
    s = strb4;
    repeat (20) cyc1();
    chk("abort_quiet", strb4 - s, 0);
    chk("abort_no_done", done_n4, 0);
    start4 = 1;
    abort4 = 1;
    cyc1();
    start4 = 0;
    abort4 = 0;
    chk("abort_wins_start", int'(busy4), 0);
    repeat (8) cyc1();
    load(1);
    clr_mon();
    kick4(0, 0);
    wait_done4("restart", 3000);
    chk("restart_seq", first_bad(4, q4), -1);
    chk("restart_c", c_errors(), 0);

    period = 1;
    clr_mon();
    kick4(1, 0);
    for (int t = 0; t < 400 && !(we4 && c4 == 4'd15); t++) cyc1();
    abort4 = 1;
    cyc1();
    abort4 = 0;
    chk("final_abort_we", we_n4, 16);
    chk("final_abort_busy", int'(busy4), 0);
    repeat (5) cyc1();
    chk("final_abort_done", done_n4, 0);

    period = 4;
    clr_mon();
    kick4(1, 0);
    wait_rd(3, 1000);
    chk("pre_reset_busy", int'(busy4), 1);
    #1 reset_n = 0;
    #1 chk("async_reset_outs", outs4(), 0);
    cyc1();
    cyc1();
    reset_n = 1;
    s = strb4;
    repeat (12) cyc1();
    chk("post_reset_busy", int'(busy4), 0);
    chk("post_reset_quiet", strb4 - s, 0);

    clr_mon();
    for (int t = 0; t < 20 && tick_en; t++) cyc1();
    start2 = 1;
    cyc1();
    start2 = 0;
    for (int t = 0; t < 500 && done_n2 == 0; t++) cyc1();
    chk("n2_strobes", strb2, 24);
    chk("n2_pend", pend2, 1);
    chk("n2_done_n", done_n2, 1);
    chk("n2_done_lat", done_cyc2 - last_we2, 1);
    chk("n2_excl", excl2, 0);
    chk("n2_seq", first_bad(2, q2), -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
